// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
// Imported by the interface, the digit-adjust cell and the top level.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_WIDTH = 4;
    localparam int BCD_DIGITS      = 3;
    localparam int BCD_MAX_VALUE   = 999;

    localparam logic [BCD_DIGIT_WIDTH-1:0] BCD_SAT_DIGIT = 4'd9;

endpackage

// File: rtl/binary_to_bcd_converter_if.sv
// Request/result bundle between a requester and the BCD converter.
// master: drives start/binary_value; slave: drives status and digits.
interface binary_to_bcd_converter_if
    import bcd_pkg::*;
#(
    parameter int INPUT_WIDTH = 10
);
    logic                       start;
    logic [INPUT_WIDTH-1:0]     binary_value;
    logic                       busy;
    logic                       done;
    logic                       overflow;
    logic [BCD_DIGIT_WIDTH-1:0] led1_display_value;
    logic [BCD_DIGIT_WIDTH-1:0] led2_display_value;
    logic [BCD_DIGIT_WIDTH-1:0] led3_display_value;

    modport master (
        output start, binary_value,
        input  busy, done, overflow,
        input  led1_display_value, led2_display_value, led3_display_value
    );

    modport slave (
        input  start, binary_value,
        output busy, done, overflow,
        output led1_display_value, led2_display_value, led3_display_value
    );
endinterface

// File: rtl/binary_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is >= 5.
// Ports: i_digit (nibble before shift), o_digit (corrected nibble).
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] i_digit,
    output logic [BCD_DIGIT_WIDTH-1:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, reset_n (sync, active-low), bus (slave: start/value in,
// busy/done/overflow and three registered digits out).
module binary_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int INPUT_WIDTH = 10,
    parameter int DIGITS      = BCD_DIGITS
)(
    input  logic                      clk,
    input  logic                      reset_n,
    binary_to_bcd_converter_if.slave  bus
);
    localparam int WORK_W = INPUT_WIDTH + BCD_DIGIT_WIDTH * DIGITS;
    localparam int CNT_W  = $clog2(INPUT_WIDTH) + 1;
    localparam int BCD_LO = INPUT_WIDTH;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(INPUT_WIDTH - 1);
    localparam logic [31:0]      MAX_VAL   = BCD_MAX_VALUE;

    logic [1:0]                 r_state;
    logic [CNT_W-1:0]           r_count;
    logic [WORK_W-1:0]          r_work;
    logic                       r_ovf_next;
    logic                       r_overflow;
    logic [BCD_DIGIT_WIDTH-1:0] r_hund;
    logic [BCD_DIGIT_WIDTH-1:0] r_tens;
    logic [BCD_DIGIT_WIDTH-1:0] r_ones;

    logic [BCD_DIGIT_WIDTH-1:0] w_adj [DIGITS];
    logic [WORK_W-1:0]          w_adjusted;
    logic [WORK_W-1:0]          w_shifted;
    logic [31:0]                w_bin_ext;

    assign w_bin_ext = 32'(bus.binary_value);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_work[BCD_LO + g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
            .o_digit (w_adj[g])
        );
    end

    // All nibbles are corrected in parallel before the single-bit shift;
    // the carry out of the top nibble is dropped (saturation covers it).
    always_comb begin
        w_adjusted = r_work;
        for (int d = 0; d < DIGITS; d++) begin
            w_adjusted[BCD_LO + d*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] = w_adj[d];
        end
        w_shifted = {w_adjusted[WORK_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_work     <= '0;
            r_ovf_next <= 1'b0;
            r_overflow <= 1'b0;
            r_hund     <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
        end else begin
            unique case (1'b1)
                (r_state == S_IDLE): begin
                    r_count <= '0;
                    if (bus.start) begin
                        r_work     <= {{(WORK_W-INPUT_WIDTH){1'b0}}, bus.binary_value};
                        r_ovf_next <= (w_bin_ext > MAX_VAL);
                        r_state    <= S_SHIFT;
                    end
                end
                (r_state == S_SHIFT): begin
                    r_work  <= w_shifted;
                    r_count <= r_count + CNT_ONE;
                    if (r_count == LAST_ITER) begin
                        r_state <= S_DONE;
                    end
                end
                (r_state == S_DONE): begin
                    if (r_ovf_next) begin
                        r_hund <= BCD_SAT_DIGIT;
                        r_tens <= BCD_SAT_DIGIT;
                        r_ones <= BCD_SAT_DIGIT;
                    end else begin
                        r_hund <= r_work[BCD_LO + 2*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH];
                        r_tens <= r_work[BCD_LO + BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH];
                        r_ones <= r_work[BCD_LO +: BCD_DIGIT_WIDTH];
                    end
                    r_overflow <= r_ovf_next;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy               = (r_state == S_SHIFT);
    assign bus.done               = (r_state == S_DONE);
    assign bus.overflow           = r_overflow;
    assign bus.led1_display_value = r_hund;
    assign bus.led2_display_value = r_tens;
    assign bus.led3_display_value = r_ones;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter: cycle model plus
// directed conversions with hand-computed digit expectations.
module tb_binary_to_bcd_converter;
    localparam int W = 10;

    logic clk;
    logic reset_n;

    binary_to_bcd_converter_if #(.INPUT_WIDTH(W)) bus ();

    binary_to_bcd_converter #(.INPUT_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Model: tracks edges since an accepted request; result appears
    // W+1 edges after acceptance, busy for the first W of them.
    bit       m_active = 0;
    int       m_age = 0;
    int       m_val = 0;
    int       m_h = 0, m_t = 0, m_o = 0;
    bit       m_ovf = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_active = 0;
            m_age = 0;
            m_h = 0; m_t = 0; m_o = 0;
            m_ovf = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age == W + 1) begin
                if (m_val > 999) begin
                    m_h = 9; m_t = 9; m_o = 9; m_ovf = 1;
                end else begin
                    m_h = m_val / 100;
                    m_t = (m_val / 10) % 10;
                    m_o = m_val % 10;
                    m_ovf = 0;
                end
                m_active = 0;
            end
        end else if (bus.start) begin
            m_active = 1;
            m_age = 0;
            m_val = int'(bus.binary_value);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(m_active && m_age < W));
        chk("done", int'(bus.done), int'(m_active && m_age == W));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        chk("hund", int'(bus.led1_display_value), m_h);
        chk("tens", int'(bus.led2_display_value), m_t);
        chk("ones", int'(bus.led3_display_value), m_o);
        chk("busy_and_done", int'(bus.busy && bus.done), 0);
        if (bus.done) done_cnt++;
    end

    task automatic lit(input string nm, input int h, input int t, input int o,
                       input int ov);
        chk({nm, "_hund"}, int'(bus.led1_display_value), h);
        chk({nm, "_tens"}, int'(bus.led2_display_value), t);
        chk({nm, "_ones"}, int'(bus.led3_display_value), o);
        chk({nm, "_ovf"}, int'(bus.overflow), ov);
    endtask

    task automatic convert(input int v);
        int n;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.binary_value = W'(v);
        @(posedge clk); #2;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(bus.done), 1);
        @(posedge clk); #2;
    endtask

    int sweep_v [6] = '{0, 9, 10, 99, 100, 999};
    int sweep_h [6] = '{0, 0, 0, 0, 1, 9};
    int sweep_t [6] = '{0, 0, 1, 9, 0, 9};
    int sweep_o [6] = '{0, 9, 0, 9, 0, 9};
    int dc0;

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.binary_value = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        lit("reset", 0, 0, 0, 0);
        chk("reset_busy", int'(bus.busy), 0);

        convert(255);
        lit("c255", 2, 5, 5, 0);
        repeat (20) @(posedge clk);
        #2;
        lit("c255_hold", 2, 5, 5, 0);

        for (int i = 0; i < 6; i++) begin
            convert(sweep_v[i]);
            lit("sweep", sweep_h[i], sweep_t[i], sweep_o[i], 0);
        end

        convert(1023);
        lit("c1023", 9, 9, 9, 1);
        convert(42);
        lit("c42", 0, 4, 2, 0);

        dc0 = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.binary_value = W'(123);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.binary_value = W'(456);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        lit("c123", 1, 2, 3, 0);
        chk("ignored_done_pulses", done_cnt - dc0, 1);

        dc0 = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.binary_value = W'(777);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk); #2;
        lit("abort", 0, 0, 0, 0);
        chk("abort_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt - dc0, 0);
        convert(777);
        lit("c777", 7, 7, 7, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
